// File: rtl/led_pwm_frame_gen.sv
// PWM frame generator: turns per-channel duty values into one on/off
// frame per PWM slot, offered to the shift-register serializer.
//
// Ports:
//   CLK, RESET      clock; synchronous active-high reset
//   wr_en/wr_addr/wr_data   shadow duty register write
//   update_req      request shadow->active copy at next period wrap
//   frame/frame_valid/frame_ready   slot pattern, valid/ready handshake
//   period_start    offered frame is slot 0
//   update_pending  an update has been requested but not yet committed
module led_pwm_frame_gen #(
    parameter int CHANNELS = 12,
    parameter int RES      = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [RES-1:0]      wr_data,
    input  logic                update_req,
    output logic [CHANNELS-1:0] frame,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                period_start,
    output logic                update_pending
);

    typedef enum logic {
        LOAD,
        OFFER
    } state_t;

    localparam logic [4:0] CH_LIM = 5'(CHANNELS);

    state_t state;
    state_t state_nxt;

    logic [RES-1:0] shadow [CHANNELS];
    logic [RES-1:0] active [CHANNELS];
    logic [RES-1:0] pwm_cnt;
    logic           pending;

    logic                handshake;
    logic                commit;
    logic                addr_ok;
    logic [CHANNELS-1:0] slot_bits;

    assign addr_ok        = ({1'b0, wr_addr} < CH_LIM);
    assign update_pending = pending;

    always_comb begin
        state_nxt = state;
        handshake = 1'b0;
        unique case (state)
            LOAD: begin
                state_nxt = OFFER;
            end
            OFFER: begin
                if (frame_valid && frame_ready) begin
                    handshake = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Commit only on the transfer of the last slot, so the very next
    // LOAD (slot 0) already uses the new duty set.
    assign commit = handshake && (pwm_cnt == '1) && pending;

    always_comb begin
        slot_bits = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            slot_bits[i] = (pwm_cnt < active[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame        <= '0;
            frame_valid  <= 1'b0;
            period_start <= 1'b0;
            pwm_cnt      <= '0;
            pending      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (state == LOAD) begin
                frame        <= slot_bits;
                period_start <= (pwm_cnt == '0);
                frame_valid  <= 1'b1;
            end
            if (handshake) begin
                frame_valid <= 1'b0;
                pwm_cnt     <= pwm_cnt + 1'b1;
            end
            // Copy reads the pre-write shadow; a same-cycle write lands
            // in shadow only and waits for a later commit.
            if (commit) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_en && addr_ok) begin
                shadow[wr_addr] <= wr_data;
            end
            // A request in the commit cycle re-arms the flag.
            if (update_req) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_frame_gen.sv
// Self-checking bench for led_pwm_frame_gen: slot-level model plus
// directed scenarios with literal expectations.
module tb_led_pwm_frame_gen;

    localparam int CH    = 12;
    localparam int RES   = 8;
    localparam int SLOTS = 1 << RES;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           wr_en;
    logic [3:0]     wr_addr;
    logic [RES-1:0] wr_data;
    logic           update_req;
    logic [CH-1:0]  frame;
    logic           frame_valid;
    logic           frame_ready;
    logic           period_start;
    logic           update_pending;

    int checks = 0;
    int errors = 0;

    led_pwm_frame_gen #(.CHANNELS(CH), .RES(RES)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .update_req     (update_req),
        .frame          (frame),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    always #5 CLK = ~CLK;

    // Slot-level model: which slot is on offer, which duty set is live.
    int m_shadow [CH];
    int m_active [CH];
    int m_slot    = 0;
    bit m_valid   = 0;
    bit m_pending = 0;
    bit m_rst     = 1;

    always @(posedge CLK) begin
        bit hs;
        bit cm;
        if (RESET) begin
            m_rst     = 1;
            m_valid   = 0;
            m_slot    = 0;
            m_pending = 0;
            for (int i = 0; i < CH; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
        end else begin
            m_rst = 0;
            hs = m_valid && frame_ready;
            cm = hs && (m_slot == SLOTS - 1) && m_pending;
            if (cm) begin
                for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
                m_pending = 0;
            end
            if (update_req) m_pending = 1;
            if (wr_en && int'(wr_addr) < CH) m_shadow[wr_addr] = int'(wr_data);
            if (hs) begin
                m_slot  = (m_slot + 1) % SLOTS;
                m_valid = 0;
            end else begin
                m_valid = 1;
            end
        end
    end

    function automatic logic [CH-1:0] exp_frame();
        logic [CH-1:0] f;
        for (int i = 0; i < CH; i++) f[i] = (m_slot < m_active[i]);
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        check("valid", 32'(frame_valid), 32'(m_valid));
        check("pending", 32'(update_pending), 32'(m_pending));
        if (m_rst) begin
            check("rst_frame", 32'(frame), 32'h0);
            check("rst_pstart", 32'(period_start), 32'h0);
        end else if (m_valid) begin
            check("frame", 32'(frame), 32'(exp_frame()));
            check("pstart", 32'(period_start), 32'(m_slot == 0));
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = RES'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic upd();
        update_req = 1'b1;
        cyc();
        update_req = 1'b0;
    endtask

    task automatic wait_slot(input int s);
        for (int k = 0; k < 3000; k++) begin
            cyc();
            if (m_valid && !m_rst && m_slot == s) return;
        end
        check("wait_slot_timeout", 32'(s), 32'hFFFF_FFFF);
    endtask

    task automatic reset_seq();
        RESET = 1'b1;
        frame_ready = 1'b1;
        repeat (3) cyc();
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_frame_lit", 32'(frame), 32'h0);
        RESET = 1'b0;
        cyc();
        check("start_valid", 32'(frame_valid), 32'h1);
        check("start_frame", 32'(frame), 32'h0);
        check("start_pstart", 32'(period_start), 32'h1);
    endtask

    initial begin
        int c0, c1, c2, c3, n;
        logic [CH-1:0] held;
        int duty [CH];

        RESET       = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        update_req  = 1'b0;
        frame_ready = 1'b1;

        reset_seq();

        duty = '{0, 1, 128, 255, 51, 100, 200, 17, 3, 64, 250, 9};
        for (int i = 0; i < CH; i++) wr(i, duty[i]);
        upd();
        check("pend_set", 32'(update_pending), 32'h1);
        wait_slot(0);
        check("pend_clr", 32'(update_pending), 32'h0);

        c0 = 0; c1 = 0; c2 = 0; c3 = 0; n = 0;
        for (int k = 0; k < 3000 && n < 2 * SLOTS; k++) begin
            if (frame_valid && frame_ready) begin
                c0 += int'(frame[0]);
                c1 += int'(frame[1]);
                c2 += int'(frame[2]);
                c3 += int'(frame[3]);
                n++;
            end
            if (n < 2 * SLOTS) cyc();
        end
        check("frames_2per", 32'(n), 32'(2 * SLOTS));
        check("cnt_d0", 32'(c0), 32'd0);
        check("cnt_d1", 32'(c1), 32'd2);
        check("cnt_d128", 32'(c2), 32'd256);
        check("cnt_d255", 32'(c3), 32'd510);

        wait_slot(50);
        check("bp_ch4_on", 32'(frame[4]), 32'h1);
        frame_ready = 1'b0;
        held = frame;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("bp_hold", 32'(frame), 32'(held));
            check("bp_valid", 32'(frame_valid), 32'h1);
        end
        frame_ready = 1'b1;
        cyc();
        cyc();
        check("bp_next_ch4", 32'(frame[4]), 32'h0);
        check("bp_next_ch7", 32'(frame[7]), 32'h0);
        check("bp_next_ch5", 32'(frame[5]), 32'h1);

        wr(0, 10);
        upd();
        wait_slot(0);
        wait_slot(100);
        wr(0, 200);
        upd();
        wait_slot(150);
        check("def_old_duty", 32'(frame[0]), 32'h0);
        check("def_pending", 32'(update_pending), 32'h1);
        wait_slot(0);
        check("def_slot0", 32'(frame[0]), 32'h1);
        wait_slot(150);
        check("def_new_duty", 32'(frame[0]), 32'h1);
        check("def_pend_clr", 32'(update_pending), 32'h0);

        wr(1, 30);
        upd();
        wait_slot(0);
        wr(1, 50);
        upd();
        wait_slot(255);
        update_req = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 4'd1;
        wr_data    = RES'(77);
        cyc();
        update_req = 1'b0;
        wr_en      = 1'b0;
        check("col_pending", 32'(update_pending), 32'h1);
        wait_slot(40);
        check("col_old_on", 32'(frame[1]), 32'h1);
        wait_slot(60);
        check("col_old_off", 32'(frame[1]), 32'h0);
        wait_slot(60);
        check("col_new_on", 32'(frame[1]), 32'h1);
        check("col_pend_clr", 32'(update_pending), 32'h0);

        wr(13, 99);
        wr(12, 99);
        wr(15, 0);
        upd();
        wait_slot(0);
        wait_slot(60);
        check("illegal_frame", 32'(frame), 32'h66F);

        frame_ready = 1'b0;
        cyc();
        check("mid_offer_valid", 32'(frame_valid), 32'h1);
        RESET = 1'b1;
        cyc();
        check("mid_rst_valid", 32'(frame_valid), 32'h0);
        check("mid_rst_frame", 32'(frame), 32'h0);
        reset_seq();
        wait_slot(100);
        check("post_rst_frame", 32'(frame), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
